// File: rtl/shifter_unit.sv
// Single-bit shifter between the B-operand register and the ALU: sout is combinational (zero latency),
// and a load-enabled register stage captures the result and flags for the next stage (one cycle, no backpressure).
module shifter_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       shift,
  input  logic             load,
  output logic [WIDTH-1:0] sout,
  output logic [WIDTH-1:0] sout_q,
  output logic             cout_q,
  output logic             zero_q,
  output logic             neg_q,
  output logic             valid_q
);

  typedef enum logic [1:0] {
    SH_PASS = 2'b00,
    SH_LSL  = 2'b01,
    SH_LSR  = 2'b10,
    SH_ASR  = 2'b11
  } shift_op_e;

  logic cout;

  // Pass-through defaults also cover unknown select values in simulation.
  always_comb begin
    sout = in;
    cout = 1'b0;
    case (shift)
      SH_LSL: begin
        sout = {in[WIDTH-2:0], 1'b0};
        cout = in[WIDTH-1];
      end
      SH_LSR: begin
        sout = {1'b0, in[WIDTH-1:1]};
        cout = in[0];
      end
      SH_ASR: begin
        sout = {in[WIDTH-1], in[WIDTH-1:1]};
        cout = in[0];
      end
      default: begin
        sout = in;
        cout = 1'b0;
      end
    endcase
  end

  // Reset wins over a load on the same edge; flags hold between loads while valid_q pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      sout_q  <= '0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b1;
      neg_q   <= 1'b0;
      valid_q <= 1'b0;
    end else if (load) begin
      sout_q  <= sout;
      cout_q  <= cout;
      zero_q  <= (sout == '0);
      neg_q   <= sout[WIDTH-1];
      valid_q <= 1'b1;
    end else begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shifter_unit.sv
// Self-checking bench for shifter_unit: vector table applied back-to-back with a scoreboard queue,
// plus hand-written reset/hold/valid-pulse sequences.
module tb_shifter_unit;

  localparam int WIDTH = 16;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] in;
  logic [1:0]       shift;
  logic             load;
  logic [WIDTH-1:0] sout;
  logic [WIDTH-1:0] sout_q;
  logic             cout_q;
  logic             zero_q;
  logic             neg_q;
  logic             valid_q;

  shifter_unit #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .in      (in),
    .shift   (shift),
    .load    (load),
    .sout    (sout),
    .sout_q  (sout_q),
    .cout_q  (cout_q),
    .zero_q  (zero_q),
    .neg_q   (neg_q),
    .valid_q (valid_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] din;
    logic [1:0]       sh;
    logic [WIDTH-1:0] exp_sout;
    logic             exp_cout;
    logic             exp_zero;
    logic             exp_neg;
  } vec_t;

  vec_t vecs[13];
  vec_t sb_q[$];
  vec_t exp_r;
  vec_t last_r;

  int checks;
  int failures;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  task automatic check_regs(input string tag, input logic [WIDTH-1:0] s, input logic c,
                            input logic z, input logic n, input logic v);
    check({tag, ".sout_q"}, 32'(sout_q), 32'(s));
    check({tag, ".cout_q"}, 32'(cout_q), 32'(c));
    check({tag, ".zero_q"}, 32'(zero_q), 32'(z));
    check({tag, ".neg_q"}, 32'(neg_q), 32'(n));
    check({tag, ".valid_q"}, 32'(valid_q), 32'(v));
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    //          in        sh     sout      c     z     n
    vecs[0]  = '{16'hF0CF, 2'b00, 16'hF0CF, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{16'hF0CF, 2'b01, 16'hE19E, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{16'hF0CF, 2'b10, 16'h7867, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{16'hF0CF, 2'b11, 16'hF867, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{16'h0000, 2'b01, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{16'h8000, 2'b01, 16'h0000, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{16'hFFFF, 2'b11, 16'hFFFF, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{16'h0001, 2'b10, 16'h0000, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{16'h0001, 2'b11, 16'h0000, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{16'h8000, 2'b11, 16'hC000, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{16'h8000, 2'b10, 16'h4000, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{16'h0000, 2'b00, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{16'hFFFF, 2'b01, 16'hFFFE, 1'b1, 1'b0, 1'b1};

    reset = 1'b1;
    load  = 1'b0;
    in    = '0;
    shift = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    check_regs("reset", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);

    @(negedge clk);
    reset = 1'b0;

    // Back-to-back loads: load stays high across every edge of the loop.
    for (int i = 0; i < 13; i++) begin
      if (i != 0) @(negedge clk);
      in    = vecs[i].din;
      shift = vecs[i].sh;
      load  = 1'b1;
      #1;
      check($sformatf("comb[%0d].sout", i), 32'(sout), 32'(vecs[i].exp_sout));
      sb_q.push_back(vecs[i]);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_empty: got 0 entries expected 1");
      end else begin
        exp_r = sb_q.pop_front();
        last_r = exp_r;
        check_regs($sformatf("reg[%0d]", i), exp_r.exp_sout, exp_r.exp_cout,
                   exp_r.exp_zero, exp_r.exp_neg, 1'b1);
      end
    end
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    // Load drops: data and flags hold, valid_q falls.
    @(negedge clk);
    load  = 1'b0;
    in    = 16'h1234;
    shift = 2'b10;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check_regs($sformatf("hold[%0d]", k), last_r.exp_sout, last_r.exp_cout,
                 last_r.exp_zero, last_r.exp_neg, 1'b0);
    end

    // Unknown select falls back to pass-through.
    @(negedge clk);
    in    = 16'hF0CF;
    shift = 2'bxx;
    #1;
    check("xsel.sout", 32'(sout), 32'h0000F0CF);

    // Reset and load on the same edge: reset wins, the load is discarded.
    @(negedge clk);
    in    = 16'hF0CF;
    shift = 2'b01;
    load  = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_regs("rst_load", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    load  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check_regs($sformatf("rst_hold[%0d]", k), 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    end

    // Single load: valid_q is a one-cycle pulse.
    @(negedge clk);
    in    = 16'hF0CF;
    shift = 2'b11;
    load  = 1'b1;
    @(posedge clk);
    #1;
    check_regs("pulse_hi", 16'hF867, 1'b1, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    load = 1'b0;
    @(posedge clk);
    #1;
    check_regs("pulse_lo", 16'hF867, 1'b1, 1'b0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
